// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the 7-segment scan controller slice.
package seg7_pkg;

    // All segments and the decimal point dark (active-low outputs).
    localparam logic [7:0] SEG_OFF = 8'hFF;

    // Active-low segment patterns {dp, g..a} for hex digits; entry 0 is rightmost.
    localparam logic [15:0][7:0] SEG_TABLE = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h98, 8'h80,
        8'hD8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

    // Ceiling log2, but never less than 1 so single-value counters still get a bit.
    function automatic int clog2Min1(input int value);
        int width;
        width = 0;
        while ((1 << width) < value) begin
            width = width + 1;
        end
        if (width < 1) begin
            width = 1;
        end
        return width;
    endfunction

endpackage

// File: rtl/seg7_scan_ctrl_decoder8.sv
// Hex nibble to active-low 7-segment pattern, decimal point bit left dark.
module Decoder8
    import seg7_pkg::*;
(
    input  logic [3:0] cnt_i,
    output logic [7:0] dout_o
);

    // Pure table lookup; the caller overrides bit 7 with its own decimal point.
    always_comb begin
        dout_o = SEG_TABLE[cnt_i];
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode multi-digit display.
// One shared decoder is stepped across the digits; the displayed value is
// double-buffered so it only changes at frame boundaries.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int NDIG  = 4,
    parameter int DIV   = 50000,
    parameter int GUARD = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [4*NDIG-1:0]   data_i,
    input  logic [NDIG-1:0]     dp_i,
    input  logic                load_i,
    input  logic                blank_i,
    input  logic                lzbEn_i,
    output logic [7:0]          seg_o,
    output logic [NDIG-1:0]     an_o,
    output logic                frame_o,
    output logic                pending_o
);

    localparam int IDXW = clog2Min1(NDIG);
    localparam int PCW  = clog2Min1(DIV);

    if (NDIG < 1 || NDIG > 8) begin : gBadNdig
        $error("seg7_scan_ctrl: NDIG must be in 1..8");
    end
    if (DIV < GUARD + 2) begin : gBadDiv
        $error("seg7_scan_ctrl: DIV must be at least GUARD+2");
    end

    logic [PCW-1:0]     pc_q, pc_d;
    logic [IDXW-1:0]    idx_q, idx_d;
    logic [4*NDIG-1:0]  activeData_q;
    logic [NDIG-1:0]    activeDp_q;
    logic [4*NDIG-1:0]  pendData_q;
    logic [NDIG-1:0]    pendDp_q;
    logic               pendFlag_q;
    logic [7:0]         seg_q, seg_d;
    logic [NDIG-1:0]    an_q, an_d;
    logic               frame_q, frame_d;

    logic               tick;
    logic               boundary;
    logic [3:0]         nib;
    logic [7:0]         decoded;
    logic [NDIG-1:0]    lzbMask;
    logic               zeroRun;

    // Slot timing: prescaler tick and the last tick of the last digit.
    always_comb begin
        tick     = (pc_q == PCW'(DIV - 1));
        boundary = tick && (idx_q == IDXW'(NDIG - 1));
    end

    // Next prescaler and digit index; idx only moves on a tick and wraps at the last digit.
    always_comb begin
        pc_d  = pc_q + PCW'(1);
        idx_d = idx_q;
        if (tick) begin
            pc_d = '0;
            if (idx_q == IDXW'(NDIG - 1)) begin
                idx_d = '0;
            end else begin
                idx_d = idx_q + IDXW'(1);
            end
        end
    end

    // Pick the active nibble for the current digit and feed the single decoder.
    always_comb begin
        nib = activeData_q[{idx_q, 2'b00} +: 4];
    end

    Decoder8 uDecoder (
        .cnt_i  (nib),
        .dout_o (decoded)
    );

    // Leading-zero mask: a digit above 0 is blank when it and everything left of it is zero.
    always_comb begin
        zeroRun = 1'b1;
        lzbMask = '0;
        for (int i = NDIG - 1; i >= 0; i--) begin
            zeroRun = zeroRun & (activeData_q[4*i +: 4] == 4'h0);
            if (i != 0) begin
                lzbMask[i] = zeroRun & lzbEn_i;
            end
        end
    end

    // Next registered outputs: anodes stay off during the guard window or while blanked.
    always_comb begin
        an_d  = '1;
        seg_d = SEG_OFF;
        if ((pc_q >= PCW'(GUARD)) && !blank_i) begin
            an_d[idx_q] = 1'b0;
            seg_d[7]    = ~activeDp_q[idx_q];
            seg_d[6:0]  = lzbMask[idx_q] ? 7'h7F : decoded[6:0];
        end
        // FRAME is registered one cycle early so it is high during the boundary cycle itself.
        frame_d = (pc_q == PCW'(DIV - 2)) && (idx_q == IDXW'(NDIG - 1));
    end

    // State update: counters, double buffer and output registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q         <= '0;
            idx_q        <= '0;
            activeData_q <= '0;
            activeDp_q   <= '0;
            pendData_q   <= '0;
            pendDp_q     <= '0;
            pendFlag_q   <= 1'b0;
            seg_q        <= SEG_OFF;
            an_q         <= '1;
            frame_q      <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            idx_q   <= idx_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
            frame_q <= frame_d;
            if (boundary) begin
                pendFlag_q <= 1'b0;
                if (load_i) begin
                    activeData_q <= data_i;
                    activeDp_q   <= dp_i;
                end else begin
                    activeData_q <= pendData_q;
                    activeDp_q   <= pendDp_q;
                end
            end else if (load_i) begin
                pendData_q <= data_i;
                pendDp_q   <= dp_i;
                pendFlag_q <= 1'b1;
            end
        end
    end

    assign seg_o     = seg_q;
    assign an_o      = an_q;
    assign frame_o   = frame_q;
    assign pending_o = pendFlag_q;

endmodule
